dmem_arbiter: RTL

//  Shares the single-port data memory between the CPU MEM stage and an external host (loader/debug).
//  CPU has fixed priority. A starvation counter forces a one-cycle CPU pipeline stall so a waiting host is served.

---
 rtl/dmem_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// and an external host (loader/debug). The CPU has fixed priority; a waiting
// host that reaches MAX_WAIT cycles gets a forced one-cycle CPU stall.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined;
// otherwise the counter ports read 0 and no counter flops exist.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  cpu_grant_cnt,
  output logic [CNT_W-1:0]  host_grant_cnt,
  output logic [CNT_W-1:0]  starve_cnt
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

  typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

  state_t              state_r;
  logic [WCNT_W-1:0]   wcnt_r;
  logic                cpuStall_r;
  logic                hostRvalid_r;
  logic [DATA_W-1:0]   hostRdata_r;

  logic                cpuReq_s;
  logic                cpuGrant_s;
  logic                hostReady_s;
  logic                handshake_s;
  logic [WCNT_W-1:0]   wcntNext_s;
  logic                goForce_s;

  // Grant decision, host handshake and next value of the host wait counter
  always_comb begin
    cpuReq_s    = cpu_mem_read | cpu_mem_write;
    cpuGrant_s  = 1'b0;
    hostReady_s = 1'b0;
    case (state_r)
      NORMAL: begin
        cpuGrant_s  = cpuReq_s;
        hostReady_s = host_valid & ~cpuReq_s;
      end
      FORCE: begin
        cpuGrant_s  = 1'b0;
        hostReady_s = host_valid;
      end
      default: begin
        cpuGrant_s  = 1'b0;
        hostReady_s = 1'b0;
      end
    endcase
    handshake_s = host_valid & hostReady_s;
    if (!host_valid || handshake_s) begin
      wcntNext_s = '0;
    end else if (wcnt_r < WAIT_MAX) begin
      wcntNext_s = wcnt_r + WCNT_W'(1);
    end else begin
      wcntNext_s = WAIT_MAX;
    end
    goForce_s = (state_r == NORMAL) && (wcntNext_s == WAIT_MAX) && !handshake_s;
  end

  // Memory port mux driven from the current owner; idle bus is all zeros
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpuGrant_s) begin
      mem_read  = cpu_mem_read & ~cpu_mem_write;
      mem_write = cpu_mem_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (handshake_s) begin
      mem_read  = ~host_we;
      mem_write = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Arbitration FSM with registered stall, wait counter and host read return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= NORMAL;
      cpuStall_r   <= 1'b0;
      wcnt_r       <= '0;
      hostRvalid_r <= 1'b0;
      hostRdata_r  <= '0;
    end else begin
      wcnt_r       <= wcntNext_s;
      hostRvalid_r <= handshake_s & ~host_we;
      if (handshake_s && !host_we) begin
        hostRdata_r <= mem_rdata;
      end
      case (state_r)
        NORMAL: begin
          if (goForce_s) begin
            state_r    <= FORCE;
            cpuStall_r <= 1'b1;
          end else begin
            state_r    <= NORMAL;
            cpuStall_r <= 1'b0;
          end
        end
        FORCE: begin
          state_r    <= NORMAL;
          cpuStall_r <= 1'b0;
        end
        default: begin
          state_r    <= NORMAL;
          cpuStall_r <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rdata   = mem_rdata;
  assign host_ready  = hostReady_s;
  assign cpu_stall   = cpuStall_r;
  assign host_rvalid = hostRvalid_r;
  assign host_rdata  = hostRdata_r;

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] cpuCnt_r;
  logic [CNT_W-1:0] hostCnt_r;
  logic [CNT_W-1:0] starveCnt_r;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      satInc = v + CNT_W'(1);
    end else begin
      satInc = v;
    end
  endfunction

  // Saturating usage statistics: CPU accesses, host handshakes, forced stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpuCnt_r    <= '0;
      hostCnt_r   <= '0;
      starveCnt_r <= '0;
    end else begin
      cpuCnt_r    <= satInc(cpuCnt_r, cpuGrant_s);
      hostCnt_r   <= satInc(hostCnt_r, handshake_s);
      starveCnt_r <= satInc(starveCnt_r, goForce_s);
    end
  end

  assign cpu_grant_cnt  = cpuCnt_r;
  assign host_grant_cnt = hostCnt_r;
  assign starve_cnt     = starveCnt_r;
`else
  assign cpu_grant_cnt  = '0;
  assign host_grant_cnt = '0;
  assign starve_cnt     = '0;
`endif

endmodule
